// File: rtl/and_n_pkg.sv
// Shared types and elaboration-time helpers for the pipelined AND-reduction tree.
package and_n_pkg;

    // Index width large enough for the widest legal operand (1024 bits).
    localparam int IDX_W = 10;

    // Result of one tree node: AND of its span, and the absolute bit index
    // of the lowest 0 inside that span (0 when the span is all ones).
    typedef struct packed {
        logic              and_bit;
        logic [IDX_W-1:0]  zero_index;
    } node_res_t;

    // Integer ceil(log_fanin(width)), never less than one level.
    function automatic int calc_levels(input int width, input int fanin);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        while (span < width) begin
            span = span * fanin;
            lv++;
        end
        return (lv < 1) ? 1 : lv;
    endfunction

    function automatic int div_ceil(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int pow_int(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

endpackage

// File: rtl/and_n_node.sv
// One FANIN-input tree node: AND of the children plus the zero index of the
// lowest-numbered child that contains a 0. Purely combinational.
module and_n_node
    import and_n_pkg::*;
#(
    parameter int FANIN = 4
) (
    input  node_res_t [FANIN-1:0] kids,
    output node_res_t             res
);

    // Scan from the top child down so the lowest zero child wins last.
    always_comb begin
        res.and_bit    = 1'b1;
        res.zero_index = '0;
        for (int i = FANIN - 1; i >= 0; i--) begin
            if (!kids[i].and_bit) begin
                res.and_bit    = 1'b0;
                res.zero_index = kids[i].zero_index;
            end
        end
    end

endmodule

// File: rtl/and_n.sv
// Pipelined AND reduction with lowest-zero index. One register stage per tree
// level, one operand accepted per cycle, outputs hold between valid results.
module and_n
    import and_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FANIN = 4,
    parameter int ZW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    output logic             y,
    output logic [ZW-1:0]    zidx
);

    localparam int LEVELS = calc_levels(WIDTH, FANIN);

    for (genvar l = 0; l < LEVELS; l++) begin : lvl
        // Inputs feeding this level and nodes it contains.
        localparam int NIN  = div_ceil(WIDTH, pow_int(FANIN, l));
        localparam int NOUT = div_ceil(NIN, FANIN);

        node_res_t [NOUT*FANIN-1:0] kids;
        node_res_t [NOUT-1:0]       res;
        node_res_t [NOUT-1:0]       st_q;
        logic                       vld_in;
        logic                       vld_q;

        // Leaves carry their own bit position; slots past the operand are
        // padded with ones so they never win the zero select.
        for (genvar k = 0; k < NOUT*FANIN; k++) begin : slot
            if (k >= NIN) begin : g_pad
                assign kids[k] = '{and_bit: 1'b1, zero_index: '0};
            end else if (l == 0) begin : g_bit
                assign kids[k] = '{and_bit: a[k], zero_index: IDX_W'(k)};
            end else begin : g_prev
                assign kids[k] = lvl[l-1].st_q[k];
            end
        end

        if (l == 0) begin : g_v0
            assign vld_in = in_valid;
        end else begin : g_vn
            assign vld_in = lvl[l-1].vld_q;
        end

        for (genvar n = 0; n < NOUT; n++) begin : node
            and_n_node #(.FANIN(FANIN)) u_node (
                .kids (kids[n*FANIN +: FANIN]),
                .res  (res[n])
            );
        end

        // Stage register: data loads only with a valid operand, else holds.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= 1'b0;
                st_q  <= '0;
            end else begin
                vld_q <= vld_in;
                if (vld_in) st_q <= res;
            end
        end
    end

    node_res_t last;
    assign last      = lvl[LEVELS-1].st_q[0];
    assign out_valid = lvl[LEVELS-1].vld_q;
    assign y         = last.and_bit;
    assign zidx      = last.zero_index[ZW-1:0];

endmodule

// File: tb/tb_and_n.sv
// Directed + random bench for and_n: default 8-bit/fanin-4 build checked every
// cycle against an end-to-end latency/hold model, plus WIDTH=5 and WIDTH=1 builds.
module tb_and_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       iv8, iv5, iv1;
    logic [7:0] a8;
    logic [4:0] a5;
    logic [0:0] a1;
    logic       ov8, y8, ov5, y5, ov1, y1;
    logic [2:0] z8, z5;
    logic [0:0] z1;

    and_n #(.WIDTH(8), .FANIN(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .a(a8),
        .out_valid(ov8), .y(y8), .zidx(z8));
    and_n #(.WIDTH(5), .FANIN(4)) dut5 (
        .clk(clk), .reset(reset), .in_valid(iv5), .a(a5),
        .out_valid(ov5), .y(y5), .zidx(z5));
    and_n #(.WIDTH(1), .FANIN(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .a(a1),
        .out_valid(ov1), .y(y1), .zidx(z1));

    typedef struct {
        logic [7:0] a;
        logic       y;
        logic [2:0] z;
    } vec_t;

    vec_t tbl[16];
    int   n_vec = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;
    logic exp_y;
    logic [2:0] exp_z;
    // Expected outputs: stage 1 = one cycle after capture, stage 2 = at the pins.
    logic       m1v, m1y, m2v, m2y;
    logic [2:0] m1z, m2z;

    function automatic logic [3:0] ref_model(input logic [7:0] v);
        logic [2:0] z;
        z = 3'd0;
        for (int i = 7; i >= 0; i--) if (!v[i]) z = 3'(i);
        return {&v, z};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive8(input logic [7:0] v, input logic ey, input logic [2:0] ez, input logic vld);
        a8 = v; exp_y = ey; exp_z = ez; iv8 = vld;
    endtask

    // Advance one clock, update the model with what the DUT saw, check dut8.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m1v = 1'b0; m1y = 1'b0; m1z = 3'd0;
            m2v = 1'b0; m2y = 1'b0; m2z = 3'd0;
        end else begin
            m2v = m1v;
            if (m1v) begin m2y = m1y; m2z = m1z; end
            m1v = iv8;
            if (iv8) begin m1y = exp_y; m1z = exp_z; end
        end
        #1;
        if (chk_en) check("dut8", 8'({ov8, y8, z8}), 8'({m2v, m2y, m2z}));
    endtask

    initial begin
        logic [7:0] v;
        logic [3:0] r;
        int acc;

        reset = 1'b1;
        iv8 = 1'b0; iv5 = 1'b0; iv1 = 1'b0;
        a8 = 8'h00; a5 = 5'h00; a1 = 1'b0;
        exp_y = 1'b0; exp_z = 3'd0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // Hand-computed operand table, streamed back to back.
        tbl[0]  = '{8'h00, 1'b0, 3'd0};
        tbl[1]  = '{8'hFF, 1'b1, 3'd0};
        tbl[2]  = '{8'hFE, 1'b0, 3'd0};
        tbl[3]  = '{8'hFD, 1'b0, 3'd1};
        tbl[4]  = '{8'hFB, 1'b0, 3'd2};
        tbl[5]  = '{8'hF7, 1'b0, 3'd3};
        tbl[6]  = '{8'hEF, 1'b0, 3'd4};
        tbl[7]  = '{8'hDF, 1'b0, 3'd5};
        tbl[8]  = '{8'hBF, 1'b0, 3'd6};
        tbl[9]  = '{8'h7F, 1'b0, 3'd7};
        tbl[10] = '{8'hF0, 1'b0, 3'd0};
        tbl[11] = '{8'h0F, 1'b0, 3'd4};
        tbl[12] = '{8'hF3, 1'b0, 3'd2};
        tbl[13] = '{8'h3F, 1'b0, 3'd6};
        tbl[14] = '{8'hFF, 1'b1, 3'd0};
        tbl[15] = '{8'h7E, 1'b0, 3'd0};
        for (int i = 0; i < 16; i++) begin
            drive8(tbl[i].a, tbl[i].y, tbl[i].z, 1'b1);
            step();
        end
        drive8(8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Reset with operands still inside the pipe; the operand presented
        // with reset is dropped, the first one after reset must come out.
        drive8(8'hFF, 1'b1, 3'd0, 1'b1);
        step();
        reset = 1'b1;
        drive8(8'h00, 1'b0, 3'd0, 1'b1);
        step();
        reset = 1'b0;
        drive8(8'hF7, 1'b0, 3'd3, 1'b1);
        step();
        drive8(8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Random stream with idle gaps, biased toward ones so y=1 occurs.
        acc = 0;
        while (acc < 1000) begin
            if ($urandom_range(0, 3) != 0) begin
                v = 8'($urandom) | (($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                r = ref_model(v);
                drive8(v, r[3], r[2:0], 1'b1);
                acc++;
            end else begin
                drive8(8'($urandom), 1'b0, 3'd0, 1'b0);
            end
            step();
        end
        drive8(8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) step();

        // WIDTH=5: padded upper slots must not disturb y or zidx.
        check("w5_rst", 8'({ov5, y5, z5}), 8'({1'b0, 1'b0, 3'd0}));
        a5 = 5'h1F; iv5 = 1'b1;
        step();
        check("w5_lat", 8'(ov5), 8'(1'b0));
        a5 = 5'h0F;
        step();
        check("w5_ones", 8'({ov5, y5, z5}), 8'({1'b1, 1'b1, 3'd0}));
        iv5 = 1'b0;
        step();
        check("w5_zero4", 8'({ov5, y5, z5}), 8'({1'b1, 1'b0, 3'd4}));
        step();
        check("w5_hold", 8'({ov5, y5, z5}), 8'({1'b0, 1'b0, 3'd4}));

        // WIDTH=1: single level, latency 1.
        check("w1_rst", 8'({ov1, y1, z1}), 8'({1'b0, 1'b0, 1'b0}));
        a1 = 1'b1; iv1 = 1'b1;
        step();
        check("w1_one", 8'({ov1, y1, z1}), 8'({1'b1, 1'b1, 1'b0}));
        a1 = 1'b0;
        step();
        check("w1_zero", 8'({ov1, y1, z1}), 8'({1'b1, 1'b0, 1'b0}));
        iv1 = 1'b0;
        step();
        check("w1_idle", 8'({ov1, y1, z1}), 8'({1'b0, 1'b0, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
